// File: rtl/vrf_operand_requester_if.sv
// Handshake and bank-request bus between an operand requester and its
// surroundings: command port, VRF bank request/grant and operand-queue credit
// return.
interface vrf_operand_requester_if #(
    parameter int unsigned NrBanks   = 8,
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned OpqWidth  = 3
) ();

    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [AddrWidth-1:0] cmd_addr_i;
    logic [LenWidth-1:0]  cmd_len_i;

    logic [NrBanks-1:0]   req_o;
    logic [AddrWidth-1:0] addr_o;
    logic [OpqWidth-1:0]  tgt_opqueue_o;
    logic                 wen_o;
    logic [NrBanks-1:0]   gnt_i;

    logic                 operand_ack_i;
    logic                 busy_o;
    logic                 done_o;

    // Requester side.
    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, gnt_i, operand_ack_i,
        output cmd_ready_o, req_o, addr_o, tgt_opqueue_o, wen_o, busy_o, done_o
    );

    // Command issuer / VRF arbiter / operand queue side.
    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, gnt_i, operand_ack_i,
        input  cmd_ready_o, req_o, addr_o, tgt_opqueue_o, wen_o, busy_o, done_o
    );

endinterface

// File: rtl/vrf_operand_requester.sv
// VRF operand requester: walks a run of consecutive VRF words, issuing one
// bank read request per word, throttled by credits from the downstream
// operand queue.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a command; no bank requests
// REQ   | requesting word ptr on bank ptr mod NrBanks while credits remain
module vrf_operand_requester #(
    parameter int unsigned NrBanks    = 8,
    parameter int unsigned AddrWidth  = 16,
    parameter int unsigned LenWidth   = 16,
    parameter int unsigned NrCredits  = 4,
    parameter int unsigned NrOpQueues = 8,
    parameter int unsigned OpQueue    = 0
) (
    input logic                         clk_i,
    input logic                         rst_i,
    vrf_operand_requester_if.slave      bus
);

    localparam int unsigned BankBits  = $clog2(NrBanks);
    localparam int unsigned CredWidth = $clog2(NrCredits + 1);
    localparam int unsigned OpqWidth  = (NrOpQueues > 1) ? $clog2(NrOpQueues) : 1;
    localparam logic [CredWidth-1:0] CredMax = CredWidth'(NrCredits);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;
    logic [LenWidth-1:0]  rem_q, rem_d;
    logic [CredWidth-1:0] cred_q, cred_d;
    logic [NrBanks-1:0]   req_q, req_d;
    logic                 done_q, done_d;
    logic                 busy_q, ready_q;
    logic                 grant;

    // A grant only counts on the bank we are actually requesting; req_q is
    // already zero whenever we are idle or out of credits.
    assign grant = (state_q == REQ) && (|(bus.gnt_i & req_q));

    // Next-state, pointer, length and credit computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        cred_d  = cred_q;
        done_d  = 1'b0;
        req_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    if (bus.cmd_len_i != '0) begin
                        ptr_d   = bus.cmd_addr_i;
                        rem_d   = bus.cmd_len_i;
                        state_d = REQ;
                    end else begin
                        // Empty command: accepted and completed at once.
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (grant) begin
                    ptr_d = ptr_q + AddrWidth'(1);
                    rem_d = rem_q - LenWidth'(1);
                    if (rem_q == LenWidth'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant and an ack in the same cycle cancel; a lone ack at full
        // credit is dropped so the counter never exceeds the queue depth.
        case ({grant, bus.operand_ack_i})
            2'b10:   cred_d = cred_q - CredWidth'(1);
            2'b01:   if (cred_q != CredMax) cred_d = cred_q + CredWidth'(1);
            default: cred_d = cred_q;
        endcase

        // Request vector is computed for the next cycle so req_o is a flop
        // output with no path from gnt_i.
        if ((state_d == REQ) && (cred_d != '0)) begin
            req_d[ptr_d[BankBits-1:0]] = 1'b1;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            cred_q  <= CredMax;
            req_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            cred_q  <= cred_d;
            req_q   <= req_d;
            done_q  <= done_d;
            busy_q  <= (state_d == REQ);
            ready_q <= (state_d == IDLE);
        end
    end

    assign bus.cmd_ready_o   = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.req_o         = req_q;
    assign bus.addr_o        = ptr_q;
    assign bus.wen_o         = 1'b0;
    assign bus.tgt_opqueue_o = OpqWidth'(OpQueue);

endmodule

// File: doc/vrf_operand_requester.md
VRF_OPERAND_REQUESTER -- requirements
Module: vrf_operand_requester

Interface
REQ-001 SHALL have parameter NrBanks, default 8, number of VRF banks; power of two, at least 2.
REQ-002 SHALL have parameter AddrWidth, default 16, width of the VRF word address.
REQ-003 SHALL have parameter LenWidth, default 16, width of the command length in 64-bit words.
REQ-004 SHALL have parameter NrCredits, default 4, depth of the downstream operand queue.
REQ-005 SHALL have parameter OpQueue, default 0, operand-queue index driven on tgt_opqueue_o.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port cmd_valid_i, input, 1 bit: command valid.
REQ-009 SHALL have port cmd_ready_o, output, 1 bit: command ready.
REQ-010 SHALL have port cmd_addr_i, input, AddrWidth bits: first word address.
REQ-011 SHALL have port cmd_len_i, input, LenWidth bits: number of words to read.
REQ-012 SHALL have port req_o, output, NrBanks bits: one-hot bank read request.
REQ-013 SHALL have port addr_o, output, AddrWidth bits: word address of the current request.
REQ-014 SHALL have port tgt_opqueue_o, output, $clog2 of the operand-queue count bits: target queue, constant OpQueue.
REQ-015 SHALL have port wen_o, output, 1 bit: write enable, tied to 0.
REQ-016 SHALL have port gnt_i, input, NrBanks bits: per-bank grant from the VRF arbiter.
REQ-017 SHALL have port operand_ack_i, input, 1 bit: the operand queue consumed one word; returns one credit.
REQ-018 SHALL have port busy_o, output, 1 bit: a command is in progress.
REQ-019 SHALL have port done_o, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-020 SHALL implement FSM states IDLE and REQ; cmd_ready_o = 1 only in IDLE; busy_o = 1 only in REQ.
REQ-021 SHALL, in IDLE on cmd_valid_i && cmd_len_i != 0, load ptr = cmd_addr_i and remaining = cmd_len_i, then enter REQ on the next cycle.
REQ-022 SHALL, in IDLE on cmd_valid_i && cmd_len_i == 0, accept the command, stay in IDLE and pulse done_o in the next cycle.
REQ-023 SHALL, in REQ with credits > 0, assert req_o[ptr mod NrBanks] only, with addr_o = ptr; req_o SHALL be all zero in IDLE or when credits == 0.
REQ-024 SHALL hold req_o and addr_o stable until gnt_i is set on the requested bank; grant bits on unrequested banks SHALL be ignored.
REQ-025 SHALL, on a grant, increment ptr modulo 2^AddrWidth (wrap from all-ones to 0), decrement remaining and consume one credit.
REQ-026 SHALL, on the grant with remaining == 1, return to IDLE and pulse done_o for exactly one cycle after that grant.
REQ-027 SHALL keep the credit counter in range 0..NrCredits: +1 on operand_ack_i, -1 on grant; unchanged when both occur in the same cycle.
REQ-028 SHALL ignore operand_ack_i when credits == NrCredits and no grant occurs; the counter SHALL saturate.
REQ-029 SHALL have one-cycle request-to-request throughput: back-to-back grants SHALL issue consecutive words on consecutive banks.
REQ-030 SHALL drive the outputs of REQ-023 to REQ-026 from registered state only, with no combinational path from gnt_i to req_o.

Reset
REQ-031 SHALL, while rst_i = 1, force IDLE, credits = NrCredits, ptr = 0, remaining = 0, req_o = 0, done_o = 0, busy_o = 0, cmd_ready_o = 1.
REQ-032 SHALL, on reset mid-command, abandon the command with no done_o pulse; the first cycle after reset release SHALL behave as REQ-031.

Verification
REQ-033 SHALL cover: NrBanks = 8, cmd addr = 5, len = 4, gnt_i always matching -> req_o one-hot banks 5, 6, 7, 0 with addr 5-8 in 4 consecutive cycles, then done_o pulse.
REQ-034 SHALL cover: NrCredits = 4, len = 6, no operand_ack_i -> exactly 4 grants, req_o drops to 0; one ack -> fifth request on the next cycle.
REQ-035 SHALL cover: cmd_len_i = 0 -> cmd_ready_o stays 1, no req_o, done_o pulse in the next cycle.
REQ-036 SHALL cover: cmd_addr_i = 0xFFFF, len = 2, AddrWidth = 16 -> addr_o 0xFFFF then 0x0000, on banks 7 then 0.
REQ-037 SHALL cover: grant withheld for 3 cycles -> req_o and addr_o stable; simultaneous grant and ack at credits = 2 -> credits remain 2.
REQ-038 SHALL cover: rst_i asserted after 2 of 5 grants -> all outputs at reset values immediately, credits = NrCredits, no done_o.
